// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection and registered drive stage feeding the tristate bus buffer.
// Every change of owner passes through a one-cycle TURN so two sources never drive together.
module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   data_in,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 bus_en,
  output logic [WIDTH-1:0]     bus_a,
  output logic                 busy
);

  localparam int OW = $clog2(N);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

  state_t           state_q;
  logic [OW-1:0]    ptr_q;
  logic [OW-1:0]    owner_q;
  logic [HW-1:0]    hold_q;
  logic [N-1:0]     grant_q;
  logic             bus_en_q;
  logic             busy_q;
  logic [WIDTH-1:0] bus_a_q;

  logic [N-1:0]     cand_d;
  logic             found_d;
  logic [OW-1:0]    sel_d;
  logic [OW-1:0]    ptr_d;
  logic [N-1:0]     grant_d;
  logic [WIDTH-1:0] slice_d;

  // grant_q is zero in IDLE and one-hot on the owner otherwise, so masking it out
  // leaves exactly the sources competing for the next grant.
  assign cand_d  = req & ~grant_q;
  assign slice_d = data_in[owner_q*WIDTH +: WIDTH];

  // Scan downward so the candidate closest to ptr in rotation order is the last one kept.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_d[(int'(ptr_q) + k) % N]) begin
        found_d = 1'b1;
        sel_d   = OW'((int'(ptr_q) + k) % N);
      end
    end
    ptr_d   = (sel_d == OW'(N - 1)) ? '0 : sel_d + 1'b1;
    grant_d = N'(1) << sel_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      hold_q   <= '0;
      grant_q  <= '0;
      bus_en_q <= 1'b0;
      busy_q   <= 1'b0;
      bus_a_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q <= TURN;
            grant_q <= grant_d;
            owner_q <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
          end
        end
        TURN: begin
          state_q  <= OWN;
          bus_en_q <= 1'b1;
          hold_q   <= '0;
          bus_a_q  <= slice_d;
        end
        OWN: begin
          bus_a_q <= slice_d;
          // Hand over on release or once a contested owner has used its full hold window.
          if (found_d && (!req[owner_q] || hold_q == HOLD_LAST)) begin
            state_q  <= TURN;
            grant_q  <= grant_d;
            owner_q  <= sel_d;
            ptr_q    <= ptr_d;
            bus_en_q <= 1'b0;
          end else if (!req[owner_q]) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            bus_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (hold_q != HOLD_LAST) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          grant_q  <= '0;
          bus_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign grant  = grant_q;
  assign owner  = owner_q;
  assign bus_en = bus_en_q;
  assign bus_a  = bus_a_q;
  assign busy   = busy_q;

endmodule
